dbus_lsu: RTL
=============

Name: dbus_lsu

Overview:
- Load/store unit on the core's data-memory port, directly upstream of the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load or store request from the execute stage and checks alignment.
- Drives the bus request for as many cycles as memory latency requires, waiting on ACKD_n.
- Returns sign- or zero-extended load data, and stalls the core while the access is outstanding.

Parameters:
BIT_WIDTH, 32, data/address width.
TIMEOUT_CYCLES, 16, cycles MREQ may stay high without ACKD_n before aborting; 0 disables the timeout.
CNT_WIDTH, 8, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  core request present; held stable until resp_done.
req_write  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101 SB=000 SH=001 SW=010.
req_addr  in  BIT_WIDTH  byte address.
req_wdata  in  BIT_WIDTH  store data (rs2).
busy  out  1  state != IDLE; core stall.
resp_done  out  1  one-cycle pulse: access finished (ok or error).
resp_err  out  2  valid with resp_done: 00 ok, 01 misaligned/illegal funct3, 10 bus timeout.
resp_rdata  out  BIT_WIDTH  extended load data; valid with resp_done && !req_write && resp_err==00.
DAD  out  BIT_WIDTH  bus address.
MREQ  out  1  bus request.
WRITE  out  1  1 = store cycle.
SIZE  out  2  00 word, 01 half, 10 byte.
DDT_o  out  BIT_WIDTH  store data, right-justified.
DDT_oe  out  1  DDT drive enable (= MREQ & WRITE); the top-level tristate uses it.
DDT_i  in  BIT_WIDTH  load data from the bus, right-justified.
ACKD_n  in  1  active-low acknowledge, sampled on the rising edge while MREQ=1.

Behaviour:
- Reset state is IDLE. While rst is high and on the edge it is sampled: MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT_o=0, DDT_oe=0, busy=0, resp_done=0, resp_err=00, resp_rdata=0, wait counter 0.
- Reset mid-access aborts the access at that edge: no resp_done is produced and MREQ drops the following cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on an edge with req_valid=1:
  - Legality check:
    - funct3 must be in {000,001,010,100,101} for loads and {000,001,010} for stores.
    - Half accesses need addr[0]=0.
    - Word accesses need addr[1:0]=00.
  - Illegal or misaligned: go to RESP with resp_err=01. MREQ is never asserted.
  - Otherwise go to ACCESS with the bus signals registered:
    - DAD = req_addr.
    - WRITE = req_write.
    - SIZE = 00 for word, 01 for half, 10 for byte.
    - DDT_o: SB → {24'b0, wdata[7:0]}; SH → {16'b0, wdata[15:0]}; SW → wdata.
    - Wait counter cleared.
- ACCESS: MREQ=1, and DAD/WRITE/SIZE/DDT_o are held constant.
  - ACKD_n==0 at an edge → go to RESP with resp_err=00. For a load, capture the extended DDT_i into resp_rdata:
    - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
    - LW: all 32 bits.
  - ACKD_n==1 → counter increments. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 on this edge → go to RESP with resp_err=10; resp_rdata is unchanged.
  - Ack and timeout on the same edge: the ack wins.
- RESP: resp_done=1 for exactly one cycle, MREQ=0, busy=1. Next state is IDLE unconditionally.
  - A new request is accepted no earlier than the edge after RESP. The core must have advanced by then; a req_valid still high in IDLE is treated as a new request.
- Latency with single-cycle memory (ACKD_n low in the first MREQ cycle): accept edge → MREQ high for 1 cycle → resp_done the next cycle. Total 2 cycles of busy after accept.
- With latency L (ack in the L-th MREQ cycle): MREQ is high for L cycles and busy for L+1 cycles.
- ACKD_n is ignored outside ACCESS.
- DAD to STDOUT/EXIT addresses is not special-cased; the memory model decodes them.

Test Plan:
1. LW at 0x0800_0010, memory returns DDT_i=0x8899_AABB with ack in the first MREQ cycle → MREQ=1 for 1 cycle with SIZE=00, WRITE=0; next cycle resp_done=1, resp_err=00, resp_rdata=0x8899_AABB.
2. LB / LBU at 0x0800_0003, DDT_i=0x0000_0080 → LB gives rdata=0xFFFF_FF80; LBU gives 0x0000_0080; SIZE=10 in both cases.
3. SH at 0x0800_0002, wdata=0x1234_5678, ack after 3 MREQ cycles → DDT_o=0x0000_5678, DDT_oe=1, SIZE=01, MREQ high exactly 3 cycles, resp_done on the 4th cycle.
4. LW at 0x0800_0001; separately, load with funct3=011 → MREQ never asserts; resp_done one cycle after accept with resp_err=01.
5. SW with ACKD_n held high, TIMEOUT_CYCLES=16 → MREQ high 16 cycles, then resp_err=10. A following SB to 0xF000_0000 with wdata=0x41 completes normally with DDT_o=0x41.
6. Assert rst during cycle 2 of a 5-cycle-latency load → MREQ=0 from the next cycle, no resp_done, busy=0. A new LW issued after reset completes normally.

Source files
------------

// File: rtl/dbus_lsu.sv
// dbus_lsu -- load/store unit sitting between the execute stage and the
// external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
//
// Takes one load or store request at a time, checks funct3 legality and
// address alignment, then holds the bus request until memory acknowledges
// or the wait budget runs out. Load data is sign/zero-extended on capture.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     request present; held stable by the core until resp_done
//   req_write     1 = store, 0 = load
//   req_funct3    RV32I load/store funct3
//   req_addr      byte address
//   req_wdata     store data (rs2)
//   busy          unit not idle; stalls the core
//   resp_done     one-cycle completion pulse
//   resp_err      00 ok, 01 misaligned/illegal funct3, 10 bus timeout
//   resp_rdata    extended load data
//   DAD           bus address
//   MREQ          bus request
//   WRITE         store cycle
//   SIZE          00 word, 01 half, 10 byte
//   DDT_o         right-justified store data
//   DDT_oe        store data drive enable (MREQ & WRITE)
//   DDT_i         right-justified load data from the bus
//   ACKD_n        active-low acknowledge, sampled while MREQ=1
module dbus_lsu #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 busy,
  output logic                 resp_done,
  output logic [1:0]           resp_err,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  output logic [BIT_WIDTH-1:0] DDT_o,
  output logic                 DDT_oe,
  input  logic [BIT_WIDTH-1:0] DDT_i,
  input  logic                 ACKD_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Counter value at which the access is abandoned: the counter starts at 0
  // in the first MREQ cycle, so MREQ stays high for TIMEOUT_CYCLES cycles.
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                 state;
  logic [2:0]             funct3_q;
  logic [CNT_WIDTH-1:0]   wait_cnt;

  logic                   req_legal;
  logic [1:0]             req_size;
  logic [BIT_WIDTH-1:0]   req_store_data;
  logic [BIT_WIDTH-1:0]   load_ext;

  // Legality and bus size of the incoming request.
  always_comb begin
    req_legal = 1'b0;
    req_size  = SIZE_WORD;
    case (req_funct3)
      3'b000: begin
        req_legal = 1'b1;
        req_size  = SIZE_BYTE;
      end
      3'b001: begin
        req_legal = ~req_addr[0];
        req_size  = SIZE_HALF;
      end
      3'b010: begin
        req_legal = (req_addr[1:0] == 2'b00);
        req_size  = SIZE_WORD;
      end
      3'b100: begin
        req_legal = ~req_write;
        req_size  = SIZE_BYTE;
      end
      3'b101: begin
        req_legal = ~req_write & ~req_addr[0];
        req_size  = SIZE_HALF;
      end
      default: begin
        req_legal = 1'b0;
        req_size  = SIZE_WORD;
      end
    endcase
  end

  // Store data, right-justified with zero fill above the access size.
  always_comb begin
    req_store_data = req_wdata;
    case (req_funct3[1:0])
      2'b00:   req_store_data = BIT_WIDTH'(req_wdata[7:0]);
      2'b01:   req_store_data = BIT_WIDTH'(req_wdata[15:0]);
      default: req_store_data = req_wdata;
    endcase
  end

  // Load extension uses the funct3 latched at accept time.
  always_comb begin
    load_ext = DDT_i;
    case (funct3_q)
      3'b000:  load_ext = {{(BIT_WIDTH-8){DDT_i[7]}}, DDT_i[7:0]};
      3'b100:  load_ext = BIT_WIDTH'(DDT_i[7:0]);
      3'b001:  load_ext = {{(BIT_WIDTH-16){DDT_i[15]}}, DDT_i[15:0]};
      3'b101:  load_ext = BIT_WIDTH'(DDT_i[15:0]);
      default: load_ext = DDT_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      resp_done  <= 1'b0;
      resp_err   <= ERR_OK;
      resp_rdata <= '0;
      DAD        <= '0;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= SIZE_WORD;
      DDT_o      <= '0;
    end else begin
      resp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            busy     <= 1'b1;
            if (req_legal) begin
              state    <= ACCESS;
              MREQ     <= 1'b1;
              DAD      <= req_addr;
              WRITE    <= req_write;
              SIZE     <= req_size;
              DDT_o    <= req_store_data;
              wait_cnt <= '0;
            end else begin
              state     <= RESP;
              resp_done <= 1'b1;
              resp_err  <= ERR_ALIGN;
            end
          end
        end

        ACCESS: begin
          if (!ACKD_n) begin
            // Ack takes priority over a timeout on the same edge.
            state     <= RESP;
            MREQ      <= 1'b0;
            resp_done <= 1'b1;
            resp_err  <= ERR_OK;
            if (!WRITE) begin
              resp_rdata <= load_ext;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
              state     <= RESP;
              MREQ      <= 1'b0;
              resp_done <= 1'b1;
              resp_err  <= ERR_TIMEOUT;
            end
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          MREQ  <= 1'b0;
        end
      endcase
    end
  end

  assign DDT_oe = MREQ & WRITE;

endmodule
